// File: rtl/bitsplease_pkg.sv
// Shared encodings for the access stage: FSM state values and the LCD status codes
// consumed by the LCD mux and the process controller.
package bitsplease_pkg;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENTRY   = 3'd1;
  localparam logic [2:0] ST_GRANTED = 3'd2;
  localparam logic [2:0] ST_DENIED  = 3'd3;
  localparam logic [2:0] ST_LOCKED  = 3'd4;
  localparam logic [2:0] ST_CHECK   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_ENTRY   = ST_ENTRY,
    S_GRANTED = ST_GRANTED,
    S_DENIED  = ST_DENIED,
    S_LOCKED  = ST_LOCKED,
    S_CHECK   = ST_CHECK
  } access_state_t;

  localparam logic [2:0] LCD_IDLE    = 3'd0;
  localparam logic [2:0] LCD_ENTRY   = 3'd1;
  localparam logic [2:0] LCD_GRANTED = 3'd2;
  localparam logic [2:0] LCD_DENIED  = 3'd3;
  localparam logic [2:0] LCD_LOCKED  = 3'd4;

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= 4'd9;
  endfunction
endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter shared by the DENIED and LOCKED hold periods.
module lockout_timer #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic [TMR_W-1:0] value,
  output logic             zero
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     value <= '0;
    else if (load)               value <= load_val;
    else if (dec && value != '0) value <= value - 1'b1;
  end

  assign zero = (value == '0);
endmodule

// File: rtl/access_control.sv
// Access-stage responder: collects a 4-digit BCD code, grants or denies, and
// locks out for a timed period after too many failed attempts.
module access_control
  import bitsplease_pkg::*;
#(
  parameter logic [15:0] PASSCODE     = 16'h1234,
  parameter int          MAX_ATTEMPTS = 3,
  parameter int          DENY_CYCLES  = 16,
  parameter int          LOCK_CYCLES  = 1000,
  parameter int          TMR_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       btn_enter,
  input  logic       btn_clear,
  input  logic       logout,
  input  logic [3:0] digit,
  output logic       access_fb,
  output logic       locked,
  output logic [2:0] lcd_code,
  output logic [2:0] digit_count,
  output logic [1:0] attempts_left
);
  localparam logic [1:0] MAX_ATT = 2'(MAX_ATTEMPTS);

  access_state_t    state;
  logic [15:0]      entry_buf;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TMR_W-1:0] tmr_load_val, tmr_value;

  // Timer is armed on the CHECK cycle so it already holds its start value on the
  // first DENIED/LOCKED cycle; the last attempt selects the lockout duration.
  assign tmr_load     = (state == S_CHECK) && (entry_buf != PASSCODE);
  assign tmr_load_val = (attempts_left == 2'd1) ? TMR_W'(LOCK_CYCLES - 1)
                                                : TMR_W'(DENY_CYCLES - 1);
  assign tmr_dec      = (state == S_DENIED) || (state == S_LOCKED);

  lockout_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      entry_buf     <= '0;
      digit_count   <= '0;
      attempts_left <= MAX_ATT;
    end else begin
      case (state)
        S_IDLE: if (enable) state <= S_ENTRY;
        S_ENTRY: begin
          if (!enable) begin
            state       <= S_IDLE;
            entry_buf   <= '0;
            digit_count <= '0;
          end else if (btn_clear) begin
            entry_buf   <= '0;
            digit_count <= '0;
          end else if (btn_enter && is_bcd(digit)) begin
            entry_buf   <= {entry_buf[11:0], digit};
            digit_count <= digit_count + 3'd1;
            if (digit_count == 3'd3) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          entry_buf   <= '0;
          digit_count <= '0;
          if (entry_buf == PASSCODE) begin
            state         <= S_GRANTED;
            attempts_left <= MAX_ATT;
          end else begin
            attempts_left <= attempts_left - 2'd1;
            state         <= (attempts_left == 2'd1) ? S_LOCKED : S_DENIED;
          end
        end
        S_GRANTED: if (logout) state <= S_IDLE;
        S_DENIED:  if (tmr_zero) state <= enable ? S_ENTRY : S_IDLE;
        S_LOCKED: begin
          if (tmr_zero) begin
            state         <= S_IDLE;
            attempts_left <= MAX_ATT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign access_fb = (state == S_GRANTED);
  assign locked    = (state == S_LOCKED);

  always_comb begin
    lcd_code = LCD_IDLE;
    case (state)
      S_ENTRY, S_CHECK: lcd_code = LCD_ENTRY;
      S_GRANTED:        lcd_code = LCD_GRANTED;
      S_DENIED:         lcd_code = LCD_DENIED;
      S_LOCKED:         lcd_code = LCD_LOCKED;
      default:          lcd_code = LCD_IDLE;
    endcase
  end
endmodule

// File: tb/tb_access_control.sv
// Directed bench for access_control: grant, deny, lockout, clear/invalid digits,
// granted-session hold and asynchronous reset during lockout.
module tb_access_control;
  logic       clk = 1'b0;
  logic       rst, enable, btn_enter, btn_clear, logout;
  logic [3:0] digit;
  logic       access_fb, locked;
  logic [2:0] lcd_code, digit_count;
  logic [1:0] attempts_left;
  int         checks = 0;
  int         errors = 0;

  access_control dut (
    .clk(clk), .rst(rst), .enable(enable), .btn_enter(btn_enter),
    .btn_clear(btn_clear), .logout(logout), .digit(digit),
    .access_fb(access_fb), .locked(locked), .lcd_code(lcd_code),
    .digit_count(digit_count), .attempts_left(attempts_left)
  );

  always #5 clk = ~clk;

  task automatic pulse_enter(input logic [3:0] d);
    @(negedge clk); digit = d; btn_enter = 1'b1;
    @(negedge clk); btn_enter = 1'b0;
  endtask

  // Returns at the negedge following the edge that moves to CHECK.
  task automatic enter_code(input logic [15:0] code);
    logic [3:0] d;
    for (int i = 3; i >= 0; i--) begin
      d = code[i*4 +: 4];
      pulse_enter(d);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0;
    logout = 1'b0; digit = 4'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({access_fb, locked, lcd_code, digit_count, attempts_left} !== {1'b0, 1'b0, 3'd0, 3'd0, 2'd3}) begin
      errors++;
      $display("FAIL reset_values got fb=%0d lk=%0d lcd=%0d cnt=%0d att=%0d want 0 0 0 0 3",
               access_fb, locked, lcd_code, digit_count, attempts_left);
    end
  endtask

  task automatic test_grant();
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (lcd_code !== 3'd1) begin errors++; $display("FAIL grant_entry lcd got %0d want 1", lcd_code); end
    enter_code(16'h1234);
    checks++;
    if (access_fb !== 1'b0) begin errors++; $display("FAIL grant_latency_check fb got %0d want 0", access_fb); end
    @(negedge clk);
    checks++;
    if ({access_fb, lcd_code, attempts_left, digit_count} !== {1'b1, 3'd2, 2'd3, 3'd0}) begin
      errors++;
      $display("FAIL grant fb=%0d lcd=%0d att=%0d cnt=%0d want 1 2 3 0", access_fb, lcd_code, attempts_left, digit_count);
    end
  endtask

  task automatic test_deny();
    @(negedge clk); logout = 1'b1;
    @(negedge clk); logout = 1'b0;
    @(negedge clk);
    enter_code(16'h1235);
    @(negedge clk);
    checks++;
    if ({access_fb, lcd_code, attempts_left} !== {1'b0, 3'd3, 2'd2}) begin
      errors++;
      $display("FAIL deny fb=%0d lcd=%0d att=%0d want 0 3 2", access_fb, lcd_code, attempts_left);
    end
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      btn_enter = (i == 5); btn_clear = (i == 8); digit = 4'd1;
    end
    checks++;
    if ({lcd_code, digit_count} !== {3'd3, 3'd0}) begin
      errors++;
      $display("FAIL deny_hold lcd=%0d cnt=%0d want 3 0", lcd_code, digit_count);
    end
    @(negedge clk);
    checks++;
    if ({lcd_code, attempts_left} !== {3'd1, 2'd2}) begin
      errors++;
      $display("FAIL deny_exit lcd=%0d att=%0d want 1 2", lcd_code, attempts_left);
    end
  endtask

  task automatic test_lockout();
    do_reset();
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      enter_code(16'h9999);
      repeat (17) @(negedge clk);
    end
    checks++;
    if ({lcd_code, attempts_left} !== {3'd1, 2'd1}) begin
      errors++;
      $display("FAIL lock_pre lcd=%0d att=%0d want 1 1", lcd_code, attempts_left);
    end
    enter_code(16'h0000);
    @(negedge clk);
    checks++;
    if ({locked, lcd_code, attempts_left} !== {1'b1, 3'd4, 2'd0}) begin
      errors++;
      $display("FAIL lock_enter lk=%0d lcd=%0d att=%0d want 1 4 0", locked, lcd_code, attempts_left);
    end
    for (int i = 1; i <= 999; i++) begin
      @(negedge clk);
      btn_enter = (i % 5 == 0) && (i < 990);
      logout    = (i % 7 == 0) && (i < 990);
      digit     = 4'd1;
    end
    checks++;
    if ({locked, lcd_code, digit_count} !== {1'b1, 3'd4, 3'd0}) begin
      errors++;
      $display("FAIL lock_hold lk=%0d lcd=%0d cnt=%0d want 1 4 0", locked, lcd_code, digit_count);
    end
    @(negedge clk);
    checks++;
    if ({locked, lcd_code, attempts_left} !== {1'b0, 3'd0, 2'd3}) begin
      errors++;
      $display("FAIL lock_exit lk=%0d lcd=%0d att=%0d want 0 0 3", locked, lcd_code, attempts_left);
    end
    @(negedge clk);
    checks++;
    if (lcd_code !== 3'd1) begin errors++; $display("FAIL lock_reentry lcd got %0d want 1", lcd_code); end
  endtask

  task automatic test_clear();
    pulse_enter(4'd1);
    pulse_enter(4'd2);
    checks++;
    if (digit_count !== 3'd2) begin errors++; $display("FAIL clear_pre cnt got %0d want 2", digit_count); end
    @(negedge clk); btn_clear = 1'b1; btn_enter = 1'b1; digit = 4'd3;
    @(negedge clk); btn_clear = 1'b0; btn_enter = 1'b0;
    checks++;
    if (digit_count !== 3'd0) begin errors++; $display("FAIL clear_beats_enter cnt got %0d want 0", digit_count); end
    pulse_enter(4'd3);
    pulse_enter(4'hA);
    checks++;
    if (digit_count !== 3'd1) begin errors++; $display("FAIL invalid_digit cnt got %0d want 1", digit_count); end
    @(negedge clk); enable = 1'b0; btn_enter = 1'b1; digit = 4'd4;
    @(negedge clk); btn_enter = 1'b0;
    checks++;
    if ({lcd_code, digit_count} !== {3'd0, 3'd0}) begin
      errors++;
      $display("FAIL disable_beats_enter lcd=%0d cnt=%0d want 0 0", lcd_code, digit_count);
    end
  endtask

  task automatic test_granted_hold();
    do_reset();
    enable = 1'b1;
    @(negedge clk);
    enter_code(16'h1234);
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      btn_enter = i[0]; btn_clear = ~i[0]; digit = 4'd2;
    end
    @(negedge clk); btn_enter = 1'b0; btn_clear = 1'b0;
    checks++;
    if ({access_fb, lcd_code, digit_count} !== {1'b1, 3'd2, 3'd0}) begin
      errors++;
      $display("FAIL granted_hold fb=%0d lcd=%0d cnt=%0d want 1 2 0", access_fb, lcd_code, digit_count);
    end
    logout = 1'b1;
    @(negedge clk); logout = 1'b0;
    checks++;
    if ({access_fb, lcd_code} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL logout fb=%0d lcd=%0d want 0 0", access_fb, lcd_code);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    enable = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      enter_code(16'h4321);
      repeat (17) @(negedge clk);
    end
    repeat (100) @(negedge clk);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL ar_pre lk got %0d want 1", locked); end
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({access_fb, locked, lcd_code, digit_count, attempts_left} !== {1'b0, 1'b0, 3'd0, 3'd0, 2'd3}) begin
      errors++;
      $display("FAIL async_reset fb=%0d lk=%0d lcd=%0d cnt=%0d att=%0d want 0 0 0 0 3",
               access_fb, locked, lcd_code, digit_count, attempts_left);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({lcd_code, attempts_left} !== {3'd1, 2'd3}) begin
      errors++;
      $display("FAIL ar_entry lcd=%0d att=%0d want 1 3", lcd_code, attempts_left);
    end
  endtask

  initial begin
    test_reset();
    test_grant();
    test_deny();
    test_lockout();
    test_clear();
    test_granted_hold();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
